// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to let a starving fetch overtake continuous data traffic.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  // Wait and starve counters share one width, sized for the larger limit.
  localparam int CNT_MAX = (TIMEOUT > STARVE_MAX) ? TIMEOUT : STARVE_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        owner;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_dm;
  logic              grant_if;
  logic [DATA_W-1:0] done_data;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = if_req && dm_req && (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_dm   = dm_req && !starve_hit;
  assign grant_if   = if_req && !grant_dm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && if_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign grant_dm = dm_req;
  assign grant_if = if_req && !dm_req;
`endif

  assign stall = (if_req && !if_ack) || (dm_req && !dm_ack);

  // Stores and timeouts return zero to the requester.
  assign done_data = (mem_ack && !mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_NONE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm || grant_if) begin
            owner     <= grant_dm ? OWN_DM : OWN_IF;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_we    <= grant_dm && dm_we;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The ack is raised on entry to DONE so it is visible for exactly that cycle.
          if (mem_ack || (wait_cnt == WAIT_LAST)) begin
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
            if (owner == OWN_IF) begin
              if_rdata <= done_data;
              if_ack   <= 1'b1;
            end else begin
              dm_rdata <= done_data;
              dm_ack   <= 1'b1;
            end
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          owner <= OWN_NONE;
          state <= ST_IDLE;
        end
        default: begin
          owner   <= OWN_NONE;
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level scoreboard against an address-keyed memory model.
// Follows ARB_STARVE_GUARD_EN so the grant-order model matches the build.
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;
  localparam int NEVER      = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, timeout_err;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          to;
    int          busy;
  } txn_t;

  txn_t if_q[$];
  txn_t dm_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int if_ack_cyc = 0;
  int dm_ack_cyc = 0;
  bit model_terr = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory latency is a pure function of the address, so every outcome is known at issue time.
  function automatic int delay_of(input logic [31:0] a);
    case (a[5:3])
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 15;
      3'd5: return NEVER;
      3'd6: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic txn_t make_txn(input logic [31:0] a, input logic we, input logic [31:0] wd);
    txn_t t;
    int d;
    d       = delay_of(a);
    t.addr  = a;
    t.we    = we;
    t.wdata = wd;
    t.to    = (d == NEVER);
    t.rdata = (we || t.to) ? 32'h0 : data_of(a);
    t.busy  = t.to ? TIMEOUT : d + 1;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus_if(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(make_txn(a, 1'b0, 32'h0));
  endtask

  task automatic applyStimulus_dm(input logic we, input logic [31:0] a, input logic [31:0] wd);
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_req   = 1'b1;
    dm_q.push_back(make_txn(a, we, wd));
  endtask

  task automatic wait_if_ack();
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (if_ack) seen = 1;
    end
    if (!seen) check("if_ack_wait", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic wait_dm_ack();
    bit seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (dm_ack) seen = 1;
    end
    if (!seen) check("dm_ack_wait", 32'd0, 32'd1);
    dm_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic run_if(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      applyStimulus_if(rand_addr());
      wait_if_ack();
    end
  endtask

  task automatic run_dm(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      applyStimulus_dm(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      wait_dm_ack();
    end
  endtask

  // Memory responder; also throws stray acks while idle, which must be ignored.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt     = 0;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        mem_ack   = (cnt == delay_of(mem_addr));
        mem_rdata = mem_we ? $urandom : data_of(mem_addr);
        cnt++;
      end else begin
        cnt       = 0;
        mem_ack   = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks grant order and fields on the memory side, and response data on acks.
  initial begin
    bit          in_busy, prev_if_ack, prev_dm_ack, exp_dm;
    int          busy_cnt, starve;
    txn_t        cur, got;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we;
    in_busy = 0; prev_if_ack = 0; prev_dm_ack = 0; busy_cnt = 0; starve = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        in_busy = 0; prev_if_ack = 0; prev_dm_ack = 0; starve = 0;
        continue;
      end
      if (mem_req && !in_busy) begin
        exp_dm = dm_req;
`ifdef ARB_STARVE_GUARD_EN
        if (if_req && dm_req && starve == STARVE_MAX) exp_dm = 0;
        if (exp_dm) begin
          if (if_req) starve++;
        end else begin
          starve = 0;
        end
`endif
        if (exp_dm ? (dm_q.size() == 0) : (if_q.size() == 0)) begin
          check(exp_dm ? "grant_owner_dm" : "grant_owner_if", 32'd0, 32'd1);
        end else begin
          cur = exp_dm ? dm_q[0] : if_q[0];
          check("grant_addr", mem_addr, cur.addr);
          check("grant_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) check("grant_wdata", mem_wdata, cur.wdata);
        end
        lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
        in_busy  = 1;
        busy_cnt = 1;
      end else if (mem_req && in_busy) begin
        busy_cnt++;
        check("hold_addr", mem_addr, lat_addr);
        check("hold_we", 32'(mem_we), 32'(lat_we));
        check("hold_wdata", mem_wdata, lat_wdata);
      end else if (!mem_req && in_busy) begin
        check("busy_cycles", busy_cnt, cur.busy);
        in_busy = 0;
      end

      if (if_ack) begin
        check("if_ack_pulse", 32'(prev_if_ack), 32'd0);
        if (!prev_if_ack) begin
          if_ack_cyc = cyc;
          if (if_q.size() == 0) begin
            check("if_ack_unexpected", 32'd1, 32'd0);
          end else begin
            got = if_q.pop_front();
            if (got.to) model_terr = 1;
            check("if_rdata", if_rdata, got.rdata);
            check("if_timeout_err", 32'(timeout_err), 32'(model_terr));
          end
        end
      end
      if (dm_ack) begin
        check("dm_ack_pulse", 32'(prev_dm_ack), 32'd0);
        if (!prev_dm_ack) begin
          dm_ack_cyc = cyc;
          if (dm_q.size() == 0) begin
            check("dm_ack_unexpected", 32'd1, 32'd0);
          end else begin
            got = dm_q.pop_front();
            if (got.to) model_terr = 1;
            check("dm_rdata", dm_rdata, got.rdata);
            check("dm_timeout_err", 32'(timeout_err), 32'(model_terr));
          end
        end
      end
      prev_if_ack = if_ack;
      prev_dm_ack = dm_ack;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_dm_ack", 32'(dm_ack), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single load");
    applyStimulus_dm(1'b0, 32'h40, 32'h0);
    #1 check("load_stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("load_mem_req", 32'(mem_req), 32'd1);
    check("load_mem_addr", mem_addr, 32'h40);
    check("load_stall_busy", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("load_dm_ack", 32'(dm_ack), 32'd1);
    check("load_dm_rdata", dm_rdata, 32'hDEADBEEF);
    check("load_stall_ack", 32'(stall), 32'd0);
    @(negedge clk);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] simultaneous requests");
    applyStimulus_if(32'h100);
    applyStimulus_dm(1'b1, 32'h80, 32'h12345678);
    fork
      wait_if_ack();
      wait_dm_ack();
    join
    check("ack_spacing", 32'(if_ack_cyc - dm_ack_cyc), 32'd3);
    @(negedge clk);

    $display("[TB] slow memory");
    applyStimulus_dm(1'b0, 32'h18, 32'h0);
    wait_dm_ack();
    check("slow_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);

    $display("[TB] timeout");
    applyStimulus_if(32'h28);
    wait_if_ack();
    applyStimulus_dm(1'b0, 32'h40, 32'h0);
    wait_dm_ack();
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    $display("[TB] reset during busy");
    applyStimulus_if(32'h28);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0;
    if_q.delete();
    model_terr = 0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_if_ack", 32'(if_ack), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus_if(32'h100);
    wait_if_ack();

    $display("[TB] random traffic");
    fork
      run_if(40, 4);
      run_dm(40, 4);
    join

    $display("[TB] continuous contention");
    fork
      run_if(8, 0);
      run_dm(14, 0);
    join

    repeat (5) @(negedge clk);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("dm_queue_drained", 32'(dm_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) requester and the data-memory (MEM-stage load/store) requester of the 5-stage pipeline.
- Sequences each access as a req/ack transaction and drives a pipeline stall while any request is outstanding.
- Data side is driven by the M-stage MemRead/MemWrite control bits; IF side is driven by the PC fetch logic.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT, 16, cycles to wait for mem_ack in BUSY before forced completion; range 2..255.
- STARVE_MAX, 4, consecutive DM grants with IF waiting before IF is forced ahead; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request (MemRead|MemWrite); held until dm_ack
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1
- dm_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; sampled with mem_ack
- mem_ack  in  1  memory completion; may arrive in any cycle mem_req=1
- stall  out  1  pipeline hold
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, grant owner=none, starve count=0, wait count=0. All outputs are 0, including mem_req, if_ack, dm_ack, rdata, and timeout_err.
- Reset asserted mid-transaction aborts it immediately: mem_req drops and no ack is issued.
- All outputs except stall are registered.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack). This is combinational from the inputs and the registered acks.
- FSM:
  - IDLE: if dm_req=1, grant DM; else if if_req=1, grant IF; else stay. On a grant, latch addr, we (IF forces we=0) and wdata into mem_* registers, set mem_req=1 next cycle, clear wait count, go to BUSY.
  - BUSY: mem_req=1 with latched fields held stable. On mem_ack=1, capture mem_rdata into the owner's rdata register (0 for stores) and go to DONE.
  - BUSY, no ack: if wait count reaches TIMEOUT-1 without mem_ack, set timeout_err=1 (sticky until reset), capture rdata=0, drop mem_req, go to DONE. Otherwise increment wait count.
  - DONE: owner's ack=1 for exactly one cycle; mem_req=0. No new grant is made in DONE, because the requester still holds req this cycle. Go to IDLE.
- Latency: mem_ack in the first BUSY cycle gives ack 2 cycles after the grant cycle. Back-to-back accesses use 3 cycles minimum each.
- Simultaneous if_req and dm_req in IDLE: DM wins. The M stage is older, and stall freezes IF anyway.
- Request dropped by the requester while in BUSY: the transaction still completes. The ack pulse is issued and is ignored by the requester.
- mem_ack while not in BUSY is ignored.
- rdata registers hold their last value outside the ack cycle.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - The starve counter increments on each DM grant made while if_req=1.
  - It clears on any IF grant.
  - When it equals STARVE_MAX and both requests are present in IDLE, IF is granted.
- Without the macro: fixed DM priority; no counter logic is present.

Test Plan:
- Single load: dm_req=1, dm_we=0, dm_addr=0x40, mem_ack returned in the first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req=1 with mem_addr=0x40 for 1 cycle; dm_ack=1 and dm_rdata=0xDEADBEEF exactly 2 cycles after the grant; stall=1 until the dm_ack cycle.
- Simultaneous requests: if_req (0x100) and dm_req store (0x80, wdata 0x12345678) raised in the same cycle -> memory sees the write to 0x80 first, then the read of 0x100; dm_ack precedes if_ack by 3 cycles.
- Slow memory: mem_ack delayed 5 cycles -> mem_addr/mem_we/mem_wdata stable throughout; ack issued the cycle after mem_ack; timeout_err stays 0.
- Timeout: mem_ack never asserted, TIMEOUT=16 -> after 16 BUSY cycles, mem_req=0, if_ack=1, if_rdata=0, timeout_err=1 and still 1 after further traffic.
- Reset mid-op: rst_n low during BUSY -> mem_req, acks and timeout_err are 0 immediately; after release, a new if_req is served normally.
- ARB_STARVE_GUARD_EN defined, STARVE_MAX=4, if_req and dm_req held continuously -> grant order DM, DM, DM, DM, IF, repeating. Without the macro: DM only.
